// File: rtl/bullet_pool_sched.sv
// -----------------------------------------------------------------------------
// bullet_pool_sched
// Shared-pool scheduler for the bullet datapath. It owns NUM_SLOTS bullet
// instances, arbitrates fire requests from two tanks, and issues one-cycle
// create pulses to the lowest free slot. It tracks each slot through
// FREE / PENDING / LIVE and enforces a per-tank live limit and fire cooldown.
//
// Ports:
//   Reset            in   async, active-high reset
//   frame_clk        in   clock, one edge per video frame
//   fire_req[1:0]    in   level fire keys (bit0 = tank0, bit1 = tank1)
//   bullet_active    in   is_bullet_active from each bullet instance
//   create           out  one-hot, one-cycle create pulse to a slot
//   slot_owner       out  per-slot owner (0 = tank0, 1 = tank1)
//   slot_busy        out  slot is PENDING or LIVE
//   live_count0/1    out  slots owned by tank0 / tank1 (PENDING + LIVE)
//   fire_ack[1:0]    out  one-cycle pulse when a tank's create is issued
//   fire_drop[1:0]   out  one-cycle pulse when a tank's request is discarded
//   cooldown_active  out  tank's cooldown counter is nonzero
// -----------------------------------------------------------------------------
module bullet_pool_sched #(
   parameter int NUM_SLOTS    = 8,
   parameter int MAX_PER_TANK = 4,
   parameter int COOLDOWN     = 15,
   parameter int PEND_TIMEOUT = 4
) (
   input  logic                 Reset,
   input  logic                 frame_clk,
   input  logic [1:0]           fire_req,
   input  logic [NUM_SLOTS-1:0] bullet_active,
   output logic [NUM_SLOTS-1:0] create,
   output logic [NUM_SLOTS-1:0] slot_owner,
   output logic [NUM_SLOTS-1:0] slot_busy,
   output logic [3:0]           live_count0,
   output logic [3:0]           live_count1,
   output logic [1:0]           fire_ack,
   output logic [1:0]           fire_drop,
   output logic [1:0]           cooldown_active
);

   localparam int IDX_W = $clog2(NUM_SLOTS);

   typedef enum logic [1:0] {SLOT_FREE, SLOT_PENDING, SLOT_LIVE} slot_state_t;

   slot_state_t          slot_st    [NUM_SLOTS];
   slot_state_t          slot_st_nx [NUM_SLOTS];
   logic [3:0]           pend_tmr    [NUM_SLOTS];
   logic [3:0]           pend_tmr_nx [NUM_SLOTS];
   logic [7:0]           cool_cnt    [2];
   logic [7:0]           cool_cnt_nx [2];
   logic [1:0]           fire_prev;
   logic [1:0]           pend, pend_nx;
   logic                 rr_ptr, rr_nx;
   logic [NUM_SLOTS-1:0] owner_nx, create_nx;
   logic [1:0]           ack_nx, drop_nx, elig;
   logic [3:0]           live0_nx, live1_nx;
   logic                 any_free, grant_valid, grant_tank;
   logic [IDX_W-1:0]     free_idx;

   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_busy[i] = (slot_st[i] != SLOT_FREE);
   end

   assign cooldown_active = {(cool_cnt[1] != 8'd0), (cool_cnt[0] != 8'd0)};

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      any_free = 1'b0;
      free_idx = '0;
      // Scan high to low so the lowest-index FREE slot wins. The search uses
      // pre-edge state: a slot freeing on this edge is not reusable until the next.
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (slot_st[i] == SLOT_FREE) begin
            any_free = 1'b1;
            free_idx = IDX_W'(i);
         end
      end

      elig[0] = pend[0] && (cool_cnt[0] == 8'd0) && (live_count0 < 4'(MAX_PER_TANK)) && any_free;
      elig[1] = pend[1] && (cool_cnt[1] == 8'd0) && (live_count1 < 4'(MAX_PER_TANK)) && any_free;

      grant_valid = |elig;
      grant_tank  = (elig == 2'b11) ? rr_ptr : elig[1];
      rr_nx       = (elig == 2'b11) ? ~rr_ptr : rr_ptr;

      ack_nx = 2'b00;
      if (grant_valid) ack_nx[grant_tank] = 1'b1;
      // A pending but ineligible request is discarded; the losing tank of a
      // contested edge is still eligible and keeps its pend bit.
      drop_nx = pend & ~elig;

      for (int t = 0; t < 2; t++) begin
         // A new key edge while a request is already pending merges into it.
         pend_nx[t]     = pend[t] ? ~(ack_nx[t] | drop_nx[t]) : (fire_req[t] & ~fire_prev[t]);
         cool_cnt_nx[t] = ack_nx[t]                ? 8'(COOLDOWN)      :
                          (cool_cnt[t] != 8'd0)    ? cool_cnt[t] - 8'd1 : 8'd0;
      end

      owner_nx  = slot_owner;
      create_nx = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_st_nx[i]  = slot_st[i];
         pend_tmr_nx[i] = pend_tmr[i];
         case (slot_st[i])
            SLOT_FREE: begin
               if (grant_valid && (free_idx == IDX_W'(i))) begin
                  slot_st_nx[i]  = SLOT_PENDING;
                  pend_tmr_nx[i] = 4'd0;
                  owner_nx[i]    = grant_tank;
                  create_nx[i]   = 1'b1;
               end
            end
            SLOT_PENDING: begin
               if (bullet_active[i])
                  slot_st_nx[i] = SLOT_LIVE;
               else if (pend_tmr[i] == 4'(PEND_TIMEOUT - 1))
                  slot_st_nx[i] = SLOT_FREE;    // bullet never came up: reclaim
               else
                  pend_tmr_nx[i] = pend_tmr[i] + 4'd1;
            end
            SLOT_LIVE: begin
               if (!bullet_active[i]) slot_st_nx[i] = SLOT_FREE;
            end
            default: slot_st_nx[i] = SLOT_FREE;
         endcase
      end

      // Live counts are recounted from next-state ownership, so a grant and a
      // free on the same edge net out and the sum always matches slot_busy.
      live0_nx = 4'd0;
      live1_nx = 4'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (slot_st_nx[i] != SLOT_FREE) begin
            if (owner_nx[i]) live1_nx = live1_nx + 4'd1;
            else             live0_nx = live0_nx + 4'd1;
         end
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         // NOTE: the per-slot state and timer arrays are plain flops, not a RAM,
         // so every element is cleared by reset.
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_st[i]  <= SLOT_FREE;
            pend_tmr[i] <= 4'd0;
         end
         cool_cnt[0] <= 8'd0;
         cool_cnt[1] <= 8'd0;
         fire_prev   <= 2'b00;
         pend        <= 2'b00;
         rr_ptr      <= 1'b0;
         slot_owner  <= '0;
         create      <= '0;
         fire_ack    <= 2'b00;
         fire_drop   <= 2'b00;
         live_count0 <= 4'd0;
         live_count1 <= 4'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_st[i]  <= slot_st_nx[i];
            pend_tmr[i] <= pend_tmr_nx[i];
         end
         cool_cnt[0] <= cool_cnt_nx[0];
         cool_cnt[1] <= cool_cnt_nx[1];
         fire_prev   <= fire_req;
         pend        <= pend_nx;
         rr_ptr      <= rr_nx;
         slot_owner  <= owner_nx;
         create      <= create_nx;
         fire_ack    <= ack_nx;
         fire_drop   <= drop_nx;
         live_count0 <= live0_nx;
         live_count1 <= live1_nx;
      end
   end

endmodule

// File: tb/tb_bullet_pool_sched.sv
// -----------------------------------------------------------------------------
// tb_bullet_pool_sched
// Self-checking bench for bullet_pool_sched with default parameters
// (8 slots, 4 per tank, cooldown 15, pending timeout 4). A table of
// per-frame vectors covers single fire, cooldown drop and expiry, and
// round-robin contention; hand-written sequences cover the live limit,
// same-edge free + grant, pending timeout and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_bullet_pool_sched;

   logic       Reset;
   logic       frame_clk;
   logic [1:0] fire_req;
   logic [7:0] bullet_active;
   logic [7:0] create, slot_owner, slot_busy;
   logic [3:0] live_count0, live_count1;
   logic [1:0] fire_ack, fire_drop, cooldown_active;

   int n_checks = 0;
   int n_fail   = 0;

   bullet_pool_sched #(
      .NUM_SLOTS(8), .MAX_PER_TANK(4), .COOLDOWN(15), .PEND_TIMEOUT(4)
   ) dut (
      .Reset           (Reset),
      .frame_clk       (frame_clk),
      .fire_req        (fire_req),
      .bullet_active   (bullet_active),
      .create          (create),
      .slot_owner      (slot_owner),
      .slot_busy       (slot_busy),
      .live_count0     (live_count0),
      .live_count1     (live_count1),
      .fire_ack        (fire_ack),
      .fire_drop       (fire_drop),
      .cooldown_active (cooldown_active)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   // One frame of stimulus: inputs applied before the edge, outputs expected after it.
   typedef struct {
      logic       rst;
      logic [1:0] fr;
      logic [7:0] ba;
      logic [7:0] cr;
      logic [1:0] ack;
      logic [1:0] drop;
      logic [7:0] busy;
      logic [7:0] own;
      logic [3:0] c0;
      logic [3:0] c1;
      logic [1:0] cd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic [1:0] fr, logic [7:0] ba, logic [7:0] cr,
                               logic [1:0] ack, logic [1:0] drop, logic [7:0] busy,
                               logic [7:0] own, logic [3:0] c0, logic [3:0] c1, logic [1:0] cd);
      vec_t v;
      v.rst = rst; v.fr = fr; v.ba = ba; v.cr = cr; v.ack = ack; v.drop = drop;
      v.busy = busy; v.own = own; v.c0 = c0; v.c1 = c1; v.cd = cd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " create"},     32'(create),          32'h0);
      check({tag, " slot_busy"},  32'(slot_busy),       32'h0);
      check({tag, " slot_owner"}, 32'(slot_owner),      32'h0);
      check({tag, " fire_ack"},   32'(fire_ack),        32'h0);
      check({tag, " fire_drop"},  32'(fire_drop),       32'h0);
      check({tag, " cooldown"},   32'(cooldown_active), 32'h0);
      check({tag, " live0"},      32'(live_count0),     32'h0);
      check({tag, " live1"},      32'(live_count1),     32'h0);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      fire_req = 2'b00;
      bullet_active = 8'h00;
      tick();
      check_all_zero("reset");
      Reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1;
      fire_req = 2'b00;
      bullet_active = 8'h00;

      // ---- Group A: single fire, cooldown drop, cooldown expiry, refire ----
      vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00));
      vecs.push_back(mk(0, 2'b01, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00));
      vecs.push_back(mk(0, 2'b01, 8'h00, 8'h01, 2'b01, 2'b00, 8'h01, 8'h00, 4'd1, 4'd0, 2'b01));
      vecs.push_back(mk(0, 2'b01, 8'h00, 8'h00, 2'b00, 2'b00, 8'h01, 8'h00, 4'd1, 4'd0, 2'b01));
      vecs.push_back(mk(0, 2'b00, 8'h01, 8'h00, 2'b00, 2'b00, 8'h01, 8'h00, 4'd1, 4'd0, 2'b01));
      vecs.push_back(mk(0, 2'b01, 8'h01, 8'h00, 2'b00, 2'b00, 8'h01, 8'h00, 4'd1, 4'd0, 2'b01));
      vecs.push_back(mk(0, 2'b01, 8'h01, 8'h00, 2'b00, 2'b01, 8'h01, 8'h00, 4'd1, 4'd0, 2'b01));
      vecs.push_back(mk(0, 2'b01, 8'h01, 8'h00, 2'b00, 2'b00, 8'h01, 8'h00, 4'd1, 4'd0, 2'b01));
      for (int i = 0; i < 9; i++)
         vecs.push_back(mk(0, 2'b00, 8'h01, 8'h00, 2'b00, 2'b00, 8'h01, 8'h00, 4'd1, 4'd0, 2'b01));
      vecs.push_back(mk(0, 2'b00, 8'h01, 8'h00, 2'b00, 2'b00, 8'h01, 8'h00, 4'd1, 4'd0, 2'b00));
      vecs.push_back(mk(0, 2'b01, 8'h01, 8'h00, 2'b00, 2'b00, 8'h01, 8'h00, 4'd1, 4'd0, 2'b00));
      vecs.push_back(mk(0, 2'b01, 8'h01, 8'h02, 2'b01, 2'b00, 8'h03, 8'h00, 4'd2, 4'd0, 2'b01));
      vecs.push_back(mk(0, 2'b00, 8'h01, 8'h00, 2'b00, 2'b00, 8'h03, 8'h00, 4'd2, 4'd0, 2'b01));
      vecs.push_back(mk(0, 2'b00, 8'h03, 8'h00, 2'b00, 2'b00, 8'h03, 8'h00, 4'd2, 4'd0, 2'b01));
      vecs.push_back(mk(0, 2'b00, 8'h02, 8'h00, 2'b00, 2'b00, 8'h02, 8'h00, 4'd1, 4'd0, 2'b01));

      // ---- Group B: simultaneous fire, round-robin alternation ----
      vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00));
      vecs.push_back(mk(0, 2'b11, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00));
      vecs.push_back(mk(0, 2'b11, 8'h00, 8'h01, 2'b01, 2'b00, 8'h01, 8'h00, 4'd1, 4'd0, 2'b01));
      vecs.push_back(mk(0, 2'b11, 8'h00, 8'h02, 2'b10, 2'b00, 8'h03, 8'h02, 4'd1, 4'd1, 2'b11));
      vecs.push_back(mk(0, 2'b00, 8'h01, 8'h00, 2'b00, 2'b00, 8'h03, 8'h02, 4'd1, 4'd1, 2'b11));
      for (int i = 0; i < 12; i++)
         vecs.push_back(mk(0, 2'b00, 8'h03, 8'h00, 2'b00, 2'b00, 8'h03, 8'h02, 4'd1, 4'd1, 2'b11));
      vecs.push_back(mk(0, 2'b00, 8'h03, 8'h00, 2'b00, 2'b00, 8'h03, 8'h02, 4'd1, 4'd1, 2'b10));
      vecs.push_back(mk(0, 2'b00, 8'h03, 8'h00, 2'b00, 2'b00, 8'h03, 8'h02, 4'd1, 4'd1, 2'b00));
      vecs.push_back(mk(0, 2'b11, 8'h03, 8'h00, 2'b00, 2'b00, 8'h03, 8'h02, 4'd1, 4'd1, 2'b00));
      vecs.push_back(mk(0, 2'b11, 8'h03, 8'h04, 2'b10, 2'b00, 8'h07, 8'h06, 4'd1, 4'd2, 2'b10));
      vecs.push_back(mk(0, 2'b11, 8'h03, 8'h08, 2'b01, 2'b00, 8'h0F, 8'h06, 4'd2, 4'd2, 2'b11));

      for (int i = 0; i < vecs.size(); i++) begin
         fire_req      = vecs[i].fr;
         bullet_active = vecs[i].ba;
         if (vecs[i].rst) Reset = 1'b1;
         tick();
         check($sformatf("row%0d create", i),     32'(create),          32'(vecs[i].cr));
         check($sformatf("row%0d fire_ack", i),   32'(fire_ack),        32'(vecs[i].ack));
         check($sformatf("row%0d fire_drop", i),  32'(fire_drop),       32'(vecs[i].drop));
         check($sformatf("row%0d slot_busy", i),  32'(slot_busy),       32'(vecs[i].busy));
         check($sformatf("row%0d slot_owner", i), 32'(slot_owner),      32'(vecs[i].own));
         check($sformatf("row%0d live0", i),      32'(live_count0),     32'(vecs[i].c0));
         check($sformatf("row%0d live1", i),      32'(live_count1),     32'(vecs[i].c1));
         check($sformatf("row%0d cooldown", i),   32'(cooldown_active), 32'(vecs[i].cd));
         Reset = 1'b0;
      end

      // ---- Group C: live limit, same-edge free + grant, pending timeout ----
      do_reset();
      for (int k = 0; k < 4; k++) begin
         fire_req = 2'b01;
         tick();
         tick();
         check($sformatf("fill%0d create", k), 32'(create),      32'(8'h01 << k));
         check($sformatf("fill%0d live0", k),  32'(live_count0), 32'(k + 1));
         fire_req = 2'b00;
         tick();
         bullet_active[k] = 1'b1;
         repeat (16) tick();
      end
      check("full busy", 32'(slot_busy), 32'h0F);

      fire_req = 2'b01;
      tick();
      tick();
      check("limit drop",   32'(fire_drop),   32'h1);
      check("limit create", 32'(create),      32'h0);
      check("limit live0",  32'(live_count0), 32'd4);
      fire_req = 2'b00;

      // Slot 2 frees on the same edge tank1 is granted: tank1 must get slot 4.
      fire_req = 2'b10;
      tick();
      bullet_active[2] = 1'b0;
      tick();
      check("same-edge create", 32'(create),        32'h10);
      check("same-edge ack",    32'(fire_ack),      32'h2);
      check("same-edge live0",  32'(live_count0),   32'd3);
      check("same-edge live1",  32'(live_count1),   32'd1);
      check("same-edge busy",   32'(slot_busy),     32'h1B);
      check("same-edge owner4", 32'(slot_owner[4]), 32'h1);

      fire_req = 2'b00;
      tick();
      fire_req = 2'b01;
      tick();
      tick();
      check("regrant create", 32'(create),      32'h04);
      check("regrant live0",  32'(live_count0), 32'd4);
      check("regrant busy",   32'(slot_busy),   32'h1F);
      fire_req = 2'b00;
      // Slot 4 never saw bullet_active: reclaimed on the 4th edge after its grant.
      tick();
      check("timeout busy",  32'(slot_busy),   32'h0F);
      check("timeout live1", 32'(live_count1), 32'd0);

      // ---- Group D: reset mid-operation with tank1 pending ----
      bullet_active[2] = 1'b1;
      bullet_active[3] = 1'b0;
      fire_req = 2'b10;
      tick();
      check("pre-reset busy",  32'(slot_busy),   32'h07);
      check("pre-reset live0", 32'(live_count0), 32'd3);
      #2;
      Reset = 1'b1;
      #1;
      check_all_zero("async reset");
      fire_req = 2'b00;
      tick();
      Reset = 1'b0;
      bullet_active = 8'h0F;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("post-reset%0d create", i), 32'(create),    32'h0);
         check($sformatf("post-reset%0d busy", i),   32'(slot_busy), 32'h0);
         check($sformatf("post-reset%0d ack", i),    32'(fire_ack),  32'h0);
      end
      bullet_active = 8'h00;
      fire_req = 2'b10;
      tick();
      tick();
      check("post-reset fire create", 32'(create),      32'h01);
      check("post-reset fire ack",    32'(fire_ack),    32'h2);
      check("post-reset fire live1",  32'(live_count1), 32'd1);
      check("post-reset fire owner",  32'(slot_owner),  32'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
